// File: rtl/uart_cmd_parser_pkg.sv
// Shared types for the UART command-frame parser: FSM states, default sync marker
// and the frame header layout.
package uart_pkg;

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] len;
  } frame_hdr_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-strobe input, held-frame handshake, payload read port and error pulses of the
// UART command parser; master = byte source / frame consumer, slave = parser.
interface uart_cmd_parser_if #(
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          frame_valid;
  logic          frame_ready;
  logic [7:0]    frame_cmd;
  logic [LW-1:0] frame_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_chk;
  logic          err_len;
  logic          err_drop;
  logic          err_timeout;

  modport master (
    output rx_dv, rx_byte, frame_ready, rd_addr,
    input  frame_valid, frame_cmd, frame_len, rd_data,
    input  err_chk, err_len, err_drop, err_timeout
  );

  modport slave (
    input  rx_dv, rx_byte, frame_ready, rd_addr,
    output frame_valid, frame_cmd, frame_len, rd_data,
    output err_chk, err_len, err_drop, err_timeout
  );
endinterface

// File: rtl/uart_cmd_parser_frame_buf.sv
// Payload register file: MAX_LEN x 8, one synchronous write port, asynchronous read.
// Cleared on reset so out-of-frame reads never return X.
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [IW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [MAX_LEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) r_mem[i] <= 8'h00;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Addresses past the last entry exist only when MAX_LEN is not a power of two.
  if ((2 ** IW) == MAX_LEN) begin : g_rd_full
    assign o_rdata = r_mem[i_raddr];
  end else begin : g_rd_guard
    assign o_rdata = (int'(i_raddr) < MAX_LEN) ? r_mem[i_raddr] : 8'h00;
  end
endmodule

// File: rtl/uart_cmd_parser.sv
// UART command-frame parser: SYNC CMD LEN payload CHK, XOR checksum, held until handshake.
// Optional inter-byte timeout enabled by defining UART_PARSER_TIMEOUT_EN.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CLKS = 86800
) (
  input logic             clk,
  input logic             rst,
  uart_cmd_parser_if.slave bus
);
  localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         LW        = $clog2(MAX_LEN + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 1) begin : g_param_check
    $error("uart_cmd_parser: MAX_LEN must be 1..255 and TIMEOUT_CLKS >= 1");
  end

  state_t        r_state, w_state_nxt;
  frame_hdr_t    r_hdr, w_hdr_nxt;
  logic [7:0]    r_xor, w_xor_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic          w_we;
  logic          r_valid;
  logic          r_err_chk, w_err_chk;
  logic          r_err_len, w_err_len;
  logic          r_err_drop, w_err_drop;

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int GW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  logic [GW-1:0] r_gap;
  logic          w_counting;
  logic          w_timeout;
  logic          r_err_timeout;

  assign w_counting = (r_state inside {S_CMD, S_LEN, S_PAYLOAD, S_CHK});
`endif

  // Next-state, header/checksum/index updates and error decode for one byte strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_hdr_nxt   = r_hdr;
    w_xor_nxt   = r_xor;
    w_idx_nxt   = r_idx;
    w_we        = 1'b0;
    w_err_chk   = 1'b0;
    w_err_len   = 1'b0;
    w_err_drop  = 1'b0;
`ifdef UART_PARSER_TIMEOUT_EN
    w_timeout   = 1'b0;
`endif
    case (r_state)
      S_SYNC: begin
        if (bus.rx_dv && (bus.rx_byte == SYNC_BYTE)) w_state_nxt = S_CMD;
        else w_state_nxt = S_SYNC;
      end
      S_CMD: begin
        if (bus.rx_dv) begin
          w_hdr_nxt.cmd = bus.rx_byte;
          w_xor_nxt     = bus.rx_byte;
          w_state_nxt   = S_LEN;
        end else begin
          w_state_nxt = S_CMD;
        end
      end
      S_LEN: begin
        if (bus.rx_dv && (bus.rx_byte > MAX_LEN_B)) begin
          w_err_len   = 1'b1;
          w_state_nxt = S_SYNC;
        end else if (bus.rx_dv) begin
          w_hdr_nxt.len = bus.rx_byte;
          w_xor_nxt     = r_xor ^ bus.rx_byte;
          w_idx_nxt     = '0;
          w_state_nxt   = (bus.rx_byte == 8'h00) ? S_CHK : S_PAYLOAD;
        end else begin
          w_state_nxt = S_LEN;
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_dv) begin
          w_we      = 1'b1;
          w_xor_nxt = r_xor ^ bus.rx_byte;
          // Index stops at len-1 so a full MAX_LEN frame never wraps it.
          if (8'(r_idx) == (r_hdr.len - 8'd1)) w_state_nxt = S_CHK;
          else w_idx_nxt = r_idx + IW'(1);
        end else begin
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_CHK: begin
        if (bus.rx_dv && (bus.rx_byte == r_xor)) begin
          w_state_nxt = S_HOLD;
        end else if (bus.rx_dv) begin
          w_err_chk   = 1'b1;
          w_state_nxt = S_SYNC;
        end else begin
          w_state_nxt = S_CHK;
        end
      end
      S_HOLD: begin
        w_err_drop = bus.rx_dv;
        if (r_valid && bus.frame_ready) w_state_nxt = S_SYNC;
        else w_state_nxt = S_HOLD;
      end
      default: w_state_nxt = S_SYNC;
    endcase
`ifdef UART_PARSER_TIMEOUT_EN
    // A byte on the expiry cycle takes priority over the timeout.
    if (w_counting && !bus.rx_dv && (r_gap == GW'(TIMEOUT_CLKS - 1))) begin
      w_timeout   = 1'b1;
      w_state_nxt = S_SYNC;
    end else begin
      w_timeout = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_SYNC;
      r_hdr      <= '0;
      r_xor      <= 8'h00;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_err_chk  <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hdr      <= w_hdr_nxt;
      r_xor      <= w_xor_nxt;
      r_idx      <= w_idx_nxt;
      r_valid    <= (w_state_nxt == S_HOLD);
      r_err_chk  <= w_err_chk;
      r_err_len  <= w_err_len;
      r_err_drop <= w_err_drop;
    end
  end

`ifdef UART_PARSER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap         <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_timeout;
      if (bus.rx_dv || !w_counting || w_timeout) r_gap <= '0;
      else r_gap <= r_gap + GW'(1);
    end
  end
  assign bus.err_timeout = r_err_timeout;
`else
  assign bus.err_timeout = 1'b0;
`endif

  uart_frame_buf #(.MAX_LEN(MAX_LEN), .IW(IW)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (bus.rx_byte),
    .i_raddr (bus.rd_addr),
    .o_rdata (bus.rd_data)
  );

  assign bus.frame_valid = r_valid;
  assign bus.frame_cmd   = r_hdr.cmd;
  assign bus.frame_len   = r_hdr.len[LW-1:0];
  assign bus.err_chk     = r_err_chk;
  assign bus.err_len     = r_err_len;
  assign bus.err_drop    = r_err_drop;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed + randomized bench for uart_cmd_parser against a byte-stream frame model.
// Define UART_PARSER_TIMEOUT_EN to also exercise the inter-byte timeout (TIMEOUT_CLKS=100).
module tb_uart_cmd_parser;
  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         TO_CLKS = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_cmd_parser #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TO_CLKS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes collected since SYNC, plus the frame being held.
  bit         sync_seen = 1'b0;
  logic [7:0] frm[$];
  bit         holding   = 1'b0;
  logic [7:0] held_cmd  = 8'h00;
  int         held_len  = 0;
  logic [7:0] held_pl [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sync_seen = 1'b0;
    frm.delete();
    holding = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit e_chk, output bit e_len, output bit e_drop);
    logic [7:0] x;
    e_chk = 1'b0; e_len = 1'b0; e_drop = 1'b0;
    if (holding) begin
      e_drop = 1'b1;
    end else if (!sync_seen) begin
      sync_seen = (b == SYNC);
    end else begin
      frm.push_back(b);
      if (frm.size() == 2 && int'(frm[1]) > MAX_LEN) begin
        e_len = 1'b1;
        frm.delete();
        sync_seen = 1'b0;
      end else if (frm.size() >= 2 && frm.size() == int'(frm[1]) + 3) begin
        x = 8'h00;
        for (int i = 0; i < frm.size() - 1; i++) x = x ^ frm[i];
        if (x == b) begin
          holding  = 1'b1;
          held_cmd = frm[0];
          held_len = int'(frm[1]);
          for (int i = 0; i < held_len; i++) held_pl[i] = frm[2 + i];
        end else begin
          e_chk = 1'b1;
        end
        frm.delete();
        sync_seen = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit ec, el, ed;
    @(negedge clk);
    bus.rx_dv = 1'b1;
    bus.rx_byte = b;
    model_byte(b, ec, el, ed);
    @(posedge clk);
    #1;
    bus.rx_dv = 1'b0;
    bus.rx_byte = 8'h00;
    chk("err_chk", 32'(bus.err_chk), 32'(ec));
    chk("err_len", 32'(bus.err_len), 32'(el));
    chk("err_drop", 32'(bus.err_drop), 32'(ed));
    chk("err_timeout", 32'(bus.err_timeout), 32'd0);
    chk("frame_valid", 32'(bus.frame_valid), 32'(holding));
    if (holding) begin
      chk("frame_cmd", 32'(bus.frame_cmd), 32'(held_cmd));
      chk("frame_len", 32'(bus.frame_len), 32'(held_len));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk("idle_errs", {28'd0, bus.err_chk, bus.err_len, bus.err_drop, bus.err_timeout}, 32'd0);
      chk("idle_valid", 32'(bus.frame_valid), 32'(holding));
    end
  endtask

  task automatic check_frame();
    chk("hold_cmd", 32'(bus.frame_cmd), 32'(held_cmd));
    chk("hold_len", 32'(bus.frame_len), 32'(held_len));
    for (int i = 0; i < MAX_LEN; i++) begin
      bus.rd_addr = 4'(i);
      #1;
      if (i < held_len) chk("rd_data", 32'(bus.rd_data), 32'(held_pl[i]));
      else chk("rd_nox", 32'($isunknown(bus.rd_data)), 32'd0);
    end
  endtask

  task automatic handshake(input bit with_byte);
    bit ec, el, ed;
    ec = 1'b0; el = 1'b0; ed = 1'b0;
    @(negedge clk);
    bus.frame_ready = 1'b1;
    if (with_byte) begin
      bus.rx_dv = 1'b1;
      bus.rx_byte = 8'($urandom);
      model_byte(bus.rx_byte, ec, el, ed);
    end
    @(posedge clk);
    #1;
    bus.frame_ready = 1'b0;
    bus.rx_dv = 1'b0;
    holding = 1'b0;
    chk("hs_valid", 32'(bus.frame_valid), 32'd0);
    chk("hs_drop", 32'(bus.err_drop), 32'(ed));
  endtask

  task automatic send_frame(input logic [7:0] cmd, input int len, input bit bad);
    logic [7:0] x, p;
    x = cmd ^ 8'(len);
    send(SYNC);
    send(cmd);
    send(8'(len));
    if (len <= MAX_LEN) begin
      for (int i = 0; i < len; i++) begin
        p = 8'($urandom);
        x = x ^ p;
        send(p);
      end
      send(bad ? (x ^ 8'h5A) : x);
    end
  endtask

  logic [7:0] exp3 [3] = '{8'h01, 8'h02, 8'h03};
  logic [7:0] seq;
  int         kind;

  initial begin
    bus.rx_dv = 1'b0;
    bus.rx_byte = 8'h00;
    bus.frame_ready = 1'b0;
    bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.frame_valid), 32'd0);
    chk("rst_hdr", {16'd0, bus.frame_cmd, 3'd0, bus.frame_len}, 32'd0);
    chk("rst_errs", {28'd0, bus.err_chk, bus.err_len, bus.err_drop, bus.err_timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Good frame with the documented checksum 0x13.
    foreach (exp3[i]) ;
    send(8'hA5); send(8'h10); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send(8'h13);
    chk("t1_valid", 32'(bus.frame_valid), 32'd1);
    chk("t1_cmd", 32'(bus.frame_cmd), 32'h10);
    chk("t1_len", 32'(bus.frame_len), 32'd3);
    for (int i = 0; i < 3; i++) begin
      bus.rd_addr = 4'(i);
      #1;
      chk("t1_rd", 32'(bus.rd_data), 32'(exp3[i]));
    end
    handshake(1'b0);
    idle(2);

    // Leading garbage then a zero-length frame.
    send(8'hFF); send(8'h00); send(8'hA5); send(8'h22); send(8'h00); send(8'h22);
    chk("t2_cmd", 32'(bus.frame_cmd), 32'h22);
    chk("t2_len", 32'(bus.frame_len), 32'd0);
    handshake(1'b0);

    // Bad then good checksum; SYNC-valued payload byte treated as data.
    send(8'hA5); send(8'h10); send(8'h01); send(8'h55); send(8'h00);
    chk("t3_errchk", 32'(bus.err_chk), 32'd1);
    idle(2);
    send(8'hA5); send(8'h10); send(8'h01); send(8'h55); send(8'h44);
    chk("t3_valid", 32'(bus.frame_valid), 32'd1);
    handshake(1'b0);
    send(8'hA5); send(8'h01); send(8'h01); send(8'hA5); send(8'hA5);
    chk("t3_sync_data", 32'(bus.frame_valid), 32'd1);
    handshake(1'b0);

    // Over-long LEN, then overrun of a held frame.
    send(8'hA5); send(8'h10); send(8'h11);
    chk("t4_errlen", 32'(bus.err_len), 32'd1);
    idle(2);
    send_frame(8'h3C, MAX_LEN, 1'b0);
    check_frame();
    for (int i = 0; i < 3; i++) send(8'(i + 8'h70));
    check_frame();
    handshake(1'b1);
    idle(1);

    // Asynchronous reset mid-payload.
    send(8'hA5); send(8'h10); send(8'h05); send(8'h01); send(8'h02);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus.frame_valid), 32'd0);
    chk("t5_rst_hdr", {16'd0, bus.frame_cmd, 3'd0, bus.frame_len}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h5E, 4, 1'b0);
    chk("t5_after", 32'(bus.frame_valid), 32'd1);
    check_frame();
    handshake(1'b0);

`ifdef UART_PARSER_TIMEOUT_EN
    send(SYNC); send(8'h10);
    repeat (TO_CLKS - 1) @(posedge clk);
    #1;
    chk("to_early", 32'(bus.err_timeout), 32'd0);
    @(posedge clk);
    #1;
    chk("to_pulse", 32'(bus.err_timeout), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    chk("to_single", 32'(bus.err_timeout), 32'd0);
    send(SYNC); send(8'h10);
    repeat (TO_CLKS - 1) @(posedge clk);
    send(8'h02);
    send(8'hAA); send(8'hBB); send(8'h10 ^ 8'h02 ^ 8'hAA ^ 8'hBB);
    chk("to_expiry_byte", 32'(bus.frame_valid), 32'd1);
    handshake(1'b0);
`endif

    // Randomized frames, garbage, drops and handshakes.
    for (int n = 0; n < 30; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        seq = 8'($urandom);
        if (seq == SYNC) seq = 8'h00;
        send(seq);
      end
      kind = int'($urandom_range(0, 9));
      if (kind < 7) send_frame(8'($urandom), int'($urandom_range(0, MAX_LEN)), 1'b0);
      else if (kind < 9) send_frame(8'($urandom), int'($urandom_range(1, MAX_LEN)), 1'b1);
      else send_frame(8'($urandom), int'($urandom_range(MAX_LEN + 1, 255)), 1'b0);
      if (holding) begin
        check_frame();
        for (int d = 0; d < int'($urandom_range(0, 2)); d++) send(8'($urandom));
        check_frame();
        handshake(1'($urandom_range(0, 1)));
      end
      idle(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
